// File: rtl/keccak_padder.sv
// keccak_padder: packs a 32-bit message word stream into RATE-bit blocks,
// applies Keccak multi-rate padding (PAD_BYTE ... 0x80) to the final block and
// offers each completed block downstream over an out_ready/f_ack handshake.
// One message is processed per reset.
module keccak_padder #(
    parameter int         RATE     = 1088,
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     in,
    input  logic [1:0]      byte_num,
    input  logic            is_last,
    input  logic            in_valid,
    output logic            buffer_full,
    output logic [RATE-1:0] out,
    output logic            out_ready,
    input  logic            f_ack
);

    localparam int         WORDS    = RATE / 32;
    localparam logic [5:0] FULL_CNT = 6'(WORDS);
    localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_PAD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Build the final message word: keep nbytes leading bytes, place PAD_BYTE
    // right after them, zero the rest; the block's closing 0x80 is merged in
    // when the word is also the last word of the block.
    function automatic logic [31:0] pad_word(
        input logic [31:0] data,
        input logic [1:0]  nbytes,
        input logic        at_end
    );
        logic [31:0] w;
        case (nbytes)
            2'd0:    w = {PAD_BYTE, 24'h00_0000};
            2'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
            2'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
            2'd3:    w = {data[31:8], PAD_BYTE};
            default: w = 32'h0000_0000;
        endcase
        if (at_end) begin
            w[7:0] = w[7:0] | 8'h80;
        end else begin
            w[7:0] = w[7:0];
        end
        return w;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [RATE-1:0] out_q, out_d;
    logic            out_ready_q, out_ready_d;
    logic            buffer_full_q, buffer_full_d;
    logic            accept_s;
    logic            handoff_s;
    logic            at_end_s;

    // Next-state logic: word acceptance, padding generation and block handoff.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        accept_s  = in_valid & ~buffer_full_q;
        handoff_s = out_ready_q & f_ack;
        at_end_s  = (cnt_q == LAST_IDX);

        if (handoff_s) begin
            // Block consumed: register content is kept, only the count restarts.
            cnt_d = 6'd0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept_s) begin
                        cnt_d = cnt_q + 6'd1;
                        if (is_last) begin
                            out_d   = {out_q[RATE-33:0], pad_word(in, byte_num, at_end_s)};
                            state_d = at_end_s ? ST_DONE : ST_PAD;
                        end else begin
                            out_d   = {out_q[RATE-33:0], in};
                            state_d = ST_FILL;
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_PAD: begin
                    // Zero fill; the block's final word carries the closing 0x80.
                    out_d   = {out_q[RATE-33:0], (at_end_s ? 32'h0000_0080 : 32'h0000_0000)};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = at_end_s ? ST_DONE : ST_PAD;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        out_ready_d   = (cnt_d == FULL_CNT);
        buffer_full_d = out_ready_d | (state_d != ST_FILL);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FILL;
            cnt_q         <= 6'd0;
            out_q         <= '0;
            out_ready_q   <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_ready_q   <= out_ready_d;
            buffer_full_q <= buffer_full_d;
        end
    end

    assign out         = out_q;
    assign out_ready   = out_ready_q;
    assign buffer_full = buffer_full_q;

endmodule
